// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single physical-memory line port between the instruction cache
// (client A) and the data cache (client B). One client is granted at a time.
// Ties are broken round-robin using last_b_reg. The granted client's request
// is forwarded combinationally to memory, and pmem_resp is routed back to that
// client only.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   a_pmem_*           client A (I-cache) line interface: read/write/address/
//                      wdata in, resp/rdata out
//   b_pmem_*           client B (D-cache) line interface, same shape as A
//   pmem_read/write/address/wdata
//                      request towards physical memory (granted client only)
//   pmem_resp/rdata    completion and read line from physical memory
// ---------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  // client A (instruction cache)
  input  logic              a_pmem_read,
  input  logic              a_pmem_write,
  input  logic [ADDR_W-1:0] a_pmem_address,
  input  logic [LINE_W-1:0] a_pmem_wdata,
  output logic              a_pmem_resp,
  output logic [LINE_W-1:0] a_pmem_rdata,
  // client B (data cache)
  input  logic              b_pmem_read,
  input  logic              b_pmem_write,
  input  logic [ADDR_W-1:0] b_pmem_address,
  input  logic [LINE_W-1:0] b_pmem_wdata,
  output logic              b_pmem_resp,
  output logic [LINE_W-1:0] b_pmem_rdata,
  // physical memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_b_reg, last_b_next;   // 1 = B was the last client served

  logic a_req;
  logic b_req;

  assign a_req = a_pmem_read | a_pmem_write;
  assign b_req = b_pmem_read | b_pmem_write;

  // Read data is broadcast to both clients; only resp qualifies it.
  assign a_pmem_rdata = pmem_rdata;
  assign b_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      last_b_reg <= 1'b1;            // A wins the first tie after reset
    end else begin
      state_reg  <= state_next;
      last_b_reg <= last_b_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_b_next  = last_b_reg;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    a_pmem_resp  = 1'b0;
    b_pmem_resp  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Memory outputs stay low here, so a stray pmem_resp is ignored.
        if (a_req && b_req) begin
          state_next = last_b_reg ? SERVE_A : SERVE_B;
        end else if (a_req) begin
          state_next = SERVE_A;
        end else if (b_req) begin
          state_next = SERVE_B;
        end
      end

      SERVE_A: begin
        // Gating on a_req makes an abort drop every pmem output in the
        // same cycle the client lets go.
        if (a_req) begin
          pmem_read    = a_pmem_read;
          pmem_write   = a_pmem_write;
          pmem_address = a_pmem_address;
          pmem_wdata   = a_pmem_wdata;
        end
        a_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          state_next  = IDLE;
          last_b_next = 1'b0;
        end else if (!a_req) begin
          state_next  = IDLE;        // abort: fairness history untouched
        end
      end

      SERVE_B: begin
        if (b_req) begin
          pmem_read    = b_pmem_read;
          pmem_write   = b_pmem_write;
          pmem_address = b_pmem_address;
          pmem_wdata   = b_pmem_wdata;
        end
        b_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          state_next  = IDLE;
          last_b_next = 1'b1;
        end else if (!b_req) begin
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Cycle-stepped environment: two client models, a memory model with
// configurable latency, and a scoreboard queue holding the expected order of
// requests at the memory port. Each test task drives its scenario through
// run_cycle() and makes its own scenario-specific comparisons.
// ---------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  typedef struct packed {
    logic              client;   // 0 = A, 1 = B
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  logic              clk;
  logic              rst;
  logic              a_pmem_read, a_pmem_write;
  logic [ADDR_W-1:0] a_pmem_address;
  logic [LINE_W-1:0] a_pmem_wdata;
  logic              a_pmem_resp;
  logic [LINE_W-1:0] a_pmem_rdata;
  logic              b_pmem_read, b_pmem_write;
  logic [ADDR_W-1:0] b_pmem_address;
  logic [LINE_W-1:0] b_pmem_wdata;
  logic              b_pmem_resp;
  logic [LINE_W-1:0] b_pmem_rdata;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_pmem_read    (a_pmem_read),
    .a_pmem_write   (a_pmem_write),
    .a_pmem_address (a_pmem_address),
    .a_pmem_wdata   (a_pmem_wdata),
    .a_pmem_resp    (a_pmem_resp),
    .a_pmem_rdata   (a_pmem_rdata),
    .b_pmem_read    (b_pmem_read),
    .b_pmem_write   (b_pmem_write),
    .b_pmem_address (b_pmem_address),
    .b_pmem_wdata   (b_pmem_wdata),
    .b_pmem_resp    (b_pmem_resp),
    .b_pmem_rdata   (b_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // scoreboard: expected order of requests at the memory port
  txn_t exp_q[$];
  // client models
  txn_t a_pend[$], b_pend[$];
  txn_t a_cur, b_cur;
  bit   a_act, b_act, a_cool, b_cool;
  int   a_start_cyc, b_start_cyc, a_grant_cyc, b_grant_cyc, a_resp_cyc, b_resp_cyc;
  int   a_done, b_done;
  // memory model
  int   mem_lat     = 3;
  int   mem_cnt     = 0;
  bit   mem_valid   = 0;
  bit   mem_resp_now;
  bit   inject_resp = 0;
  bit   last_req;
  txn_t mem_cur;

  function automatic logic [LINE_W-1:0] rdata_of(input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0] d;
    if (addr == 16'h1230) d = {16{8'hA5}};
    else                  d = {8{addr ^ 16'h5A3C}};
    return d;
  endfunction

  task automatic issue(input logic c, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata);
    txn_t t;
    t.client = c; t.wr = wr; t.addr = addr; t.wdata = wdata;
    if (c) b_pend.push_back(t); else a_pend.push_back(t);
    exp_q.push_back(t);
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic run_cycle();
    logic ea, eb;
    // clients drive their requests
    if (a_cool) a_cool = 1'b0;
    else if (!a_act && a_pend.size() != 0) begin
      a_cur = a_pend.pop_front(); a_act = 1'b1; a_start_cyc = cyc;
    end
    if (b_cool) b_cool = 1'b0;
    else if (!b_act && b_pend.size() != 0) begin
      b_cur = b_pend.pop_front(); b_act = 1'b1; b_start_cyc = cyc;
    end
    a_pmem_read    = a_act & ~a_cur.wr;
    a_pmem_write   = a_act &  a_cur.wr;
    a_pmem_address = a_act ? a_cur.addr  : '0;
    a_pmem_wdata   = a_act ? a_cur.wdata : '0;
    b_pmem_read    = b_act & ~b_cur.wr;
    b_pmem_write   = b_act &  b_cur.wr;
    b_pmem_address = b_act ? b_cur.addr  : '0;
    b_pmem_wdata   = b_act ? b_cur.wdata : '0;
    #1;
    // memory model
    last_req = pmem_read | pmem_write;
    if (last_req) begin
      if (mem_cnt == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got addr=%h rd=%b wr=%b, required no request",
                   pmem_address, pmem_read, pmem_write);
          mem_valid = 1'b0;
        end else begin
          mem_cur = exp_q.pop_front();
          mem_valid = 1'b1;
          if (pmem_address !== mem_cur.addr || pmem_write !== mem_cur.wr ||
              pmem_read !== ~mem_cur.wr) begin
            errors++;
            $display("FAIL grant_order: got addr=%h rd=%b wr=%b, required addr=%h wr=%b (client %0d)",
                     pmem_address, pmem_read, pmem_write, mem_cur.addr, mem_cur.wr, mem_cur.client);
          end
          if (mem_cur.wr) begin
            checks++;
            if (pmem_wdata !== mem_cur.wdata) begin
              errors++;
              $display("FAIL grant_wdata: got %h, required %h", pmem_wdata, mem_cur.wdata);
            end
          end
          if (mem_cur.client) b_grant_cyc = cyc; else a_grant_cyc = cyc;
        end
      end
      mem_cnt++;
      mem_resp_now = mem_valid && (mem_cnt == mem_lat);
    end else begin
      mem_cnt = 0;
      mem_valid = 1'b0;
      mem_resp_now = 1'b0;
    end
    pmem_resp  = mem_resp_now | (~last_req & inject_resp);
    pmem_rdata = mem_resp_now ? rdata_of(mem_cur.addr)
                              : {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    // response routing
    ea = mem_resp_now & ~mem_cur.client;
    eb = mem_resp_now &  mem_cur.client;
    checks++;
    if (a_pmem_resp !== ea || b_pmem_resp !== eb) begin
      errors++;
      $display("FAIL resp_route: got a=%b b=%b, required a=%b b=%b (cycle %0d)",
               a_pmem_resp, b_pmem_resp, ea, eb, cyc);
    end
    checks++;
    if (a_pmem_rdata !== pmem_rdata || b_pmem_rdata !== pmem_rdata) begin
      errors++;
      $display("FAIL rdata_bcast: got a=%h b=%h, required %h", a_pmem_rdata, b_pmem_rdata, pmem_rdata);
    end
    if (ea && a_act) begin
      if (!a_cur.wr) begin
        checks++;
        if (a_pmem_rdata !== rdata_of(a_cur.addr)) begin
          errors++;
          $display("FAIL a_rdata: got %h, required %h", a_pmem_rdata, rdata_of(a_cur.addr));
        end
      end
      $display("txn A %s addr=%h done at cycle %0d", a_cur.wr ? "wr" : "rd", a_cur.addr, cyc);
      a_act = 1'b0; a_cool = 1'b1; a_resp_cyc = cyc; a_done++;
      mem_valid = 1'b0;
    end
    if (eb && b_act) begin
      if (!b_cur.wr) begin
        checks++;
        if (b_pmem_rdata !== rdata_of(b_cur.addr)) begin
          errors++;
          $display("FAIL b_rdata: got %h, required %h", b_pmem_rdata, rdata_of(b_cur.addr));
        end
      end
      $display("txn B %s addr=%h done at cycle %0d", b_cur.wr ? "wr" : "rd", b_cur.addr, cyc);
      b_act = 1'b0; b_cool = 1'b1; b_resp_cyc = cyc; b_done++;
      mem_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((a_act || b_act || a_cool || b_cool || a_pend.size() != 0 ||
            b_pend.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      run_cycle();
      n++;
    end
    checks++;
    if (a_act || b_act || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending grants after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete(); a_pend.delete(); b_pend.delete();
      a_act = 1'b0; b_act = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pmem_resp = 1'b0; pmem_rdata = '0;
    a_pmem_read = 0; a_pmem_write = 0; a_pmem_address = '0; a_pmem_wdata = '0;
    b_pmem_read = 0; b_pmem_write = 0; b_pmem_address = '0; b_pmem_wdata = '0;
    a_cur = '0; b_cur = '0; mem_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pmem_read, pmem_write, a_pmem_resp, b_pmem_resp} !== 4'b0 ||
        pmem_address !== '0 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h ra=%b rb=%b, required all 0",
               pmem_read, pmem_write, pmem_address, a_pmem_resp, b_pmem_resp);
    end
    rst = 1'b0;
    run_cycle();
    checks++;
    if (last_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got pmem request %b, required 0", last_req);
    end
  endtask

  task automatic test_single_read();
    mem_lat = 5;
    issue(1'b0, 1'b0, 16'h1230, '0);
    run_until_idle(50);
    checks++;
    if (a_grant_cyc !== a_start_cyc + 1) begin
      errors++;
      $display("FAIL read_latency: got grant at %0d, required %0d", a_grant_cyc, a_start_cyc + 1);
    end
    checks++;
    if (a_resp_cyc !== a_grant_cyc + 4) begin
      errors++;
      $display("FAIL resp_latency: got resp at %0d, required %0d", a_resp_cyc, a_grant_cyc + 4);
    end
  endtask

  task automatic test_tie_after_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 4;
    issue(1'b0, 1'b0, 16'h0100, '0);
    issue(1'b1, 1'b1, 16'h0200, 128'h0123456789ABCDEF_FEDCBA9876543210);
    run_until_idle(100);
    checks++;
    if (a_grant_cyc !== a_start_cyc + 1) begin
      errors++;
      $display("FAIL tie_first: got A grant at %0d, required %0d", a_grant_cyc, a_start_cyc + 1);
    end
    checks++;
    if (b_grant_cyc !== a_resp_cyc + 2) begin
      errors++;
      $display("FAIL back_to_back: got B grant at %0d, required %0d", b_grant_cyc, a_resp_cyc + 2);
    end
    checks++;
    if (b_resp_cyc !== b_grant_cyc + 3) begin
      errors++;
      $display("FAIL b_resp_latency: got %0d, required %0d", b_resp_cyc, b_grant_cyc + 3);
    end
  endtask

  task automatic test_round_robin();
    int a0 = a_done;
    int b0 = b_done;
    mem_lat = 2;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 16'h1000 + 16'(i * 16), '0);
      issue(1'b1, 1'b0, 16'h2000 + 16'(i * 16), '0);
    end
    run_until_idle(200);
    checks++;
    if (a_done - a0 !== 3 || b_done - b0 !== 3) begin
      errors++;
      $display("FAIL rr_count: got A=%0d B=%0d, required 3 each", a_done - a0, b_done - b0);
    end
    // after an A-only transaction the next tie must go to B
    issue(1'b0, 1'b1, 16'h3000, {4{32'hDEAD_BEEF}});
    run_until_idle(50);
    issue(1'b1, 1'b0, 16'h3100, '0);
    issue(1'b0, 1'b0, 16'h3200, '0);
    run_until_idle(100);
  endtask

  task automatic test_idle_resp();
    int a0 = a_done;
    inject_resp = 1'b1;
    repeat (3) begin
      run_cycle();
      checks++;
      if (last_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_resp_state: got pmem request %b, required 0", last_req);
      end
    end
    mem_lat = 3;
    issue(1'b0, 1'b0, 16'h0440, '0);
    run_cycle();                     // A first visible in IDLE with a stray resp
    inject_resp = 1'b0;
    run_until_idle(50);
    checks++;
    if (a_grant_cyc !== a_start_cyc + 1 || a_done - a0 !== 1) begin
      errors++;
      $display("FAIL idle_resp_grant: got grant %0d done %0d, required grant %0d done 1",
               a_grant_cyc, a_done - a0, a_start_cyc + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int r1;
    mem_lat = 3;
    issue(1'b0, 1'b0, 16'h6000, '0);  // leaves last_b = 0
    run_until_idle(50);
    mem_lat = 50;
    b_grant_cyc = -1;
    issue(1'b1, 1'b1, 16'h7000, {8{16'hC0DE}});
    for (int i = 0; i < 5 && b_grant_cyc < 0; i++) run_cycle();
    checks++;
    if (b_grant_cyc < 0) begin
      errors++;
      $display("FAIL rst_mid_grant: got no B grant, required one");
    end
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    mem_lat = 3;
    issue(1'b0, 1'b0, 16'h7100, '0);
    exp_q.push_back(b_cur);           // B keeps requesting and is retried after A
    r1 = cyc;
    run_cycle();
    checks++;
    if (last_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: got pmem request %b, required 0", last_req);
    end
    run_until_idle(100);
    checks++;
    if (a_grant_cyc !== r1 + 1) begin
      errors++;
      $display("FAIL rst_tie: got A grant at %0d, required %0d", a_grant_cyc, r1 + 1);
    end
  endtask

  task automatic test_abort();
    int abort_cyc;
    mem_lat = 1000;
    b_grant_cyc = -1;
    issue(1'b1, 1'b1, 16'h4000, {4{32'h1234_5678}});
    for (int i = 0; i < 5 && b_grant_cyc < 0; i++) run_cycle();
    checks++;
    if (b_grant_cyc < 0) begin
      errors++;
      $display("FAIL abort_grant: got no B grant, required one");
    end
    issue(1'b0, 1'b0, 16'h5000, '0);
    repeat (2) run_cycle();
    b_act = 1'b0;                     // B abandons its write
    abort_cyc = cyc;
    run_cycle();
    checks++;
    if (last_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got pmem request %b, required 0", last_req);
    end
    mem_lat = 3;
    run_until_idle(50);
    checks++;
    if (a_grant_cyc !== abort_cyc + 2) begin
      errors++;
      $display("FAIL abort_next: got A grant at %0d, required %0d", a_grant_cyc, abort_cyc + 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_round_robin();
    test_idle_resp();
    test_reset_mid_write();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
